// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch aligner.
// Holds the traceback direction codes, the nucleotide symbol encodings and
// the traceback state enum used by nw_traceback.
package nw_pkg;

    // Direction codes stored in the direction matrix during fill.
    localparam logic [1:0] DIAG    = 2'b00;
    localparam logic [1:0] UP      = 2'b01;
    localparam logic [1:0] LEFT    = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Nucleotide symbol encodings.
    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_C = 2'b01;
    localparam logic [1:0] SYM_G = 2'b10;
    localparam logic [1:0] SYM_T = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } tb_state_e;

endpackage

// File: rtl/nw_traceback.sv
// Traceback stage of the Needleman-Wunsch aligner.
// Walks the direction matrix from cell (N,N) back to (0,0), reading one
// direction code per step and emitting one aligned symbol pair per step on a
// valid/ready stream, last pair first.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en_traceB                level enable from the controller
//   dir_rd                   read strobe for direction and sequence memories
//   dir_row, dir_col         direction matrix cell address (i, j)
//   dir_data                 direction code, valid the cycle after dir_rd
//   seq_a_addr, seq_b_addr   sequence addresses i-1, j-1 (0 when index is 0)
//   seq_a_data, seq_b_data   symbols, same latency as dir_data
//   out_valid, out_ready     output handshake
//   out_a, out_b             aligned symbols (00 when the matching gap is set)
//   out_a_gap, out_b_gap     gap flags
//   out_len                  pairs accepted so far (saturates at 2N)
//   ending                   traceback complete, back to the controller
//   dir_err                  sticky illegal-direction flag
module nw_traceback
    import nw_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N + 1),
    parameter int unsigned LEN_W = $clog2(2 * N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_traceB,
    output logic             dir_rd,
    output logic [IDX_W-1:0] dir_row,
    output logic [IDX_W-1:0] dir_col,
    input  logic [1:0]       dir_data,
    output logic [IDX_W-1:0] seq_a_addr,
    output logic [IDX_W-1:0] seq_b_addr,
    input  logic [1:0]       seq_a_data,
    input  logic [1:0]       seq_b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_a,
    output logic [1:0]       out_b,
    output logic             out_a_gap,
    output logic             out_b_gap,
    output logic [LEN_W-1:0] out_len,
    output logic             ending,
    output logic             dir_err
);

    tb_state_e        state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    // High on the first EMIT cycle, when the memory read data is live.
    logic             first_q, first_d;

    // Copy of the step taken from the live read, used while stalled because
    // the memory outputs are not guaranteed to hold after the read cycle.
    logic [1:0]       dir_q, sa_q, sb_q;

    logic [1:0]       live_dir, cur_dir, cur_sa, cur_sb;
    logic             illegal_hit;
    logic             handshake;
    logic [IDX_W-1:0] step_i, step_j;

    // Boundary rows/columns force the step; the stored code is ignored there.
    always_comb begin
        illegal_hit = 1'b0;
        if (i_q == '0) begin
            live_dir = LEFT;
        end else if (j_q == '0) begin
            live_dir = UP;
        end else if (dir_data == ILLEGAL) begin
            live_dir    = DIAG;
            illegal_hit = 1'b1;
        end else begin
            live_dir = dir_data;
        end
    end

    assign cur_dir   = first_q ? live_dir   : dir_q;
    assign cur_sa    = first_q ? seq_a_data : sa_q;
    assign cur_sb    = first_q ? seq_b_data : sb_q;
    assign handshake = (state_q == EMIT) && out_ready;

    always_comb begin
        step_i = i_q;
        step_j = j_q;
        if (cur_dir != LEFT) step_i = i_q - IDX_W'(1);
        if (cur_dir != UP)   step_j = j_q - IDX_W'(1);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        len_d   = len_q;
        err_d   = err_q;
        first_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_traceB) begin
                    i_d     = IDX_W'(N);
                    j_d     = IDX_W'(N);
                    len_d   = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!en_traceB) begin
                    state_d = IDLE;
                end else begin
                    first_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (!en_traceB) begin
                    state_d = IDLE;
                end else begin
                    if (first_q && illegal_hit) err_d = 1'b1;
                    if (handshake) begin
                        i_d = step_i;
                        j_d = step_j;
                        if (len_q != LEN_W'(2 * N)) len_d = len_q + LEN_W'(1);
                        state_d = ((step_i == '0) && (step_j == '0)) ? DONE : FETCH;
                    end
                end
            end
            DONE: begin
                if (!en_traceB) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            dir_q   <= DIAG;
            sa_q    <= SYM_A;
            sb_q    <= SYM_A;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            len_q   <= len_d;
            err_q   <= err_d;
            first_q <= first_d;
            if ((state_q == EMIT) && first_q) begin
                dir_q <= live_dir;
                sa_q  <= seq_a_data;
                sb_q  <= seq_b_data;
            end
        end
    end

    // Read bus is only driven during FETCH so it idles at zero.
    always_comb begin
        dir_rd     = (state_q == FETCH);
        dir_row    = '0;
        dir_col    = '0;
        seq_a_addr = '0;
        seq_b_addr = '0;
        if (state_q == FETCH) begin
            dir_row = i_q;
            dir_col = j_q;
            if (i_q != '0) seq_a_addr = i_q - IDX_W'(1);
            if (j_q != '0) seq_b_addr = j_q - IDX_W'(1);
        end
    end

    always_comb begin
        out_valid = (state_q == EMIT);
        out_a     = SYM_A;
        out_b     = SYM_A;
        out_a_gap = 1'b0;
        out_b_gap = 1'b0;
        if (state_q == EMIT) begin
            case (cur_dir)
                UP: begin
                    out_a     = cur_sa;
                    out_b_gap = 1'b1;
                end
                LEFT: begin
                    out_a_gap = 1'b1;
                    out_b     = cur_sb;
                end
                default: begin
                    out_a = cur_sa;
                    out_b = cur_sb;
                end
            endcase
        end
    end

    assign out_len = len_q;
    assign ending  = (state_q == DONE);
    assign dir_err = err_q;

endmodule

// File: tb/tb_nw_traceback.sv
module tb_nw_traceback;
    import nw_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 3;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_traceB;
    logic             dir_rd;
    logic [IDX_W-1:0] dir_row, dir_col, seq_a_addr, seq_b_addr;
    logic [1:0]       dir_data, seq_a_data, seq_b_data;
    logic             out_valid, out_ready;
    logic [1:0]       out_a, out_b;
    logic             out_a_gap, out_b_gap;
    logic [LEN_W-1:0] out_len;
    logic             ending, dir_err;

    nw_traceback #(.N(N), .IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_traceB  (en_traceB),
        .dir_rd     (dir_rd),
        .dir_row    (dir_row),
        .dir_col    (dir_col),
        .dir_data   (dir_data),
        .seq_a_addr (seq_a_addr),
        .seq_b_addr (seq_b_addr),
        .seq_a_data (seq_a_data),
        .seq_b_data (seq_b_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_a_gap  (out_a_gap),
        .out_b_gap  (out_b_gap),
        .out_len    (out_len),
        .ending     (ending),
        .dir_err    (dir_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories with one-cycle registered read; garbage when not read.
    logic [1:0] dir_mem [0:N][0:N];
    logic [1:0] sa_mem [0:N-1];
    logic [1:0] sb_mem [0:N-1];

    always @(posedge clk) begin
        if (dir_rd) begin
            dir_data   <= dir_mem[dir_row][dir_col];
            seq_a_data <= sa_mem[seq_a_addr];
            seq_b_data <= sb_mem[seq_b_addr];
        end else begin
            dir_data   <= 2'($urandom);
            seq_a_data <= 2'($urandom);
            seq_b_data <= 2'($urandom);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected pair list from the alignment rules.
    logic [1:0] ea[$], eb[$];
    bit         ega[$], egb[$];
    bit         exp_err;

    function automatic void build_model();
        int i = N;
        int j = N;
        logic [1:0] d;
        ea.delete(); eb.delete(); ega.delete(); egb.delete();
        exp_err = 0;
        while (!(i == 0 && j == 0)) begin
            if (i == 0)      d = LEFT;
            else if (j == 0) d = UP;
            else             d = dir_mem[i][j];
            if (d == ILLEGAL) begin
                exp_err = 1;
                d = DIAG;
            end
            if (d == DIAG) begin
                ea.push_back(sa_mem[i-1]); eb.push_back(sb_mem[j-1]);
                ega.push_back(0); egb.push_back(0);
                i--; j--;
            end else if (d == UP) begin
                ea.push_back(sa_mem[i-1]); eb.push_back(SYM_A);
                ega.push_back(0); egb.push_back(1);
                i--;
            end else begin
                ea.push_back(SYM_A); eb.push_back(sb_mem[j-1]);
                ega.push_back(1); egb.push_back(0);
                j--;
            end
        end
    endfunction

    task automatic fill_dir(input logic [1:0] code);
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= N; c++) dir_mem[r][c] = code;
    endtask

    task automatic set_acgt();
        for (int k = 0; k < N; k++) begin
            sa_mem[k] = 2'(k);
            sb_mem[k] = 2'(k);
        end
    endtask

    task automatic do_walk(input int stall_pair, input int stall_len, input bit rand_ready,
                           input int abort_after, output int t_start, output int t_end);
        int n, stalls, sc, np;
        bit r;
        build_model();
        np    = ea.size();
        t_end = -1;
        @(negedge clk);
        en_traceB = 1;
        out_ready = 1;
        t_start   = cyc;
        @(negedge clk);
        chk("fetch_rd", dir_rd, 1);
        chk("fetch_row", dir_row, N);
        chk("fetch_col", dir_col, N);
        chk("fetch_aaddr", seq_a_addr, N - 1);
        chk("start_err_clr", dir_err, 0);
        chk("fetch_valid", out_valid, 0);
        for (int k = 0; k < np; k++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin
                chk("valid_timeout", out_valid, 1);
                return;
            end
            chk("valid_latency", n, 1);
            chk("pair_a", out_a, ea[k]);
            chk("pair_b", out_b, eb[k]);
            chk("pair_agap", out_a_gap, ega[k]);
            chk("pair_bgap", out_b_gap, egb[k]);
            chk("pair_len", out_len, k);
            stalls = (k == stall_pair) ? stall_len : 0;
            sc = 0;
            forever begin
                if (rand_ready) r = (sc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                else            r = (stalls == 0);
                out_ready = r;
                @(negedge clk);
                if (r) break;
                if (stalls > 0) stalls--;
                sc++;
                chk("stall_valid", out_valid, 1);
                chk("stall_a", out_a, ea[k]);
                chk("stall_b", out_b, eb[k]);
                chk("stall_len", out_len, k);
            end
            if (k == np - 1) begin
                chk("ending", ending, 1);
                chk("len_final", out_len, np);
                t_end = cyc;
            end else begin
                chk("post_hs_valid", out_valid, 0);
                chk("not_ending", ending, 0);
                chk("len_inc", out_len, k + 1);
            end
            if (k + 1 == abort_after) begin
                en_traceB = 0;
                @(negedge clk);
                chk("abort_valid", out_valid, 0);
                chk("abort_ending", ending, 0);
                chk("abort_rd", dir_rd, 0);
                return;
            end
        end
        chk("dir_err", dir_err, exp_err);
        @(negedge clk);
        @(negedge clk);
        chk("done_hold", ending, 1);
        chk("err_hold", dir_err, exp_err);
        en_traceB = 0;
        @(negedge clk);
        chk("idle_ending", ending, 0);
        chk("idle_err", dir_err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ts, te, d_base, d_stall, n;
        rst       = 1;
        en_traceB = 0;
        out_ready = 0;
        fill_dir(DIAG);
        set_acgt();
        repeat (3) @(negedge clk);
        en_traceB = 1;  // reset must win over enable
        @(negedge clk);
        en_traceB = 0;
        rst       = 0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_rd", dir_rd, 0);
        chk("rst_ending", ending, 0);
        chk("rst_err", dir_err, 0);
        chk("rst_len", out_len, 0);
        chk("rst_row", dir_row, 0);
        chk("rst_a", out_a, 0);

        // All DIAG, ACGT vs ACGT.
        do_walk(-1, 0, 0, -1, ts, te);
        d_base = te - ts;
        chk("base_duration", d_base, 2 * N + 1);

        // All UP; row 0 holds illegal codes that must be ignored.
        fill_dir(UP);
        for (int c = 0; c <= N; c++) dir_mem[0][c] = ILLEGAL;
        do_walk(-1, 0, 0, -1, ts, te);

        // Backpressure on the 2nd pair for 5 cycles.
        fill_dir(DIAG);
        do_walk(1, 5, 0, -1, ts, te);
        d_stall = te - ts;
        chk("stall_delay", d_stall, d_base + 5);

        // Illegal code at (N,N); cleared by the next start.
        dir_mem[N][N] = ILLEGAL;
        do_walk(-1, 0, 0, -1, ts, te);
        fill_dir(DIAG);
        do_walk(-1, 0, 0, -1, ts, te);

        // Abandon after two handshakes, then restart from (N,N).
        do_walk(-1, 0, 0, 2, ts, te);
        do_walk(-1, 0, 0, -1, ts, te);

        // Randomized matrices, sequences and backpressure.
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r <= N; r++)
                for (int c = 0; c <= N; c++) dir_mem[r][c] = 2'($urandom_range(0, 3));
            for (int k = 0; k < N; k++) begin
                sa_mem[k] = 2'($urandom);
                sb_mem[k] = 2'($urandom);
            end
            do_walk(-1, 0, 1, -1, ts, te);
        end

        // Reset in EMIT with out_valid high, after one pair and an illegal hit.
        fill_dir(DIAG);
        dir_mem[N-1][N-1] = ILLEGAL;
        @(negedge clk);
        en_traceB = 1;
        out_ready = 1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);  // first handshake taken
        out_ready = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_err", dir_err, 1);
        chk("pre_rst_len", out_len, 1);
        rst = 1;
        @(negedge clk);
        chk("emit_rst_valid", out_valid, 0);
        chk("emit_rst_err", dir_err, 0);
        chk("emit_rst_len", out_len, 0);
        chk("emit_rst_a", out_a, 0);
        chk("emit_rst_b", out_b, 0);
        chk("emit_rst_gaps", {out_a_gap, out_b_gap}, 0);
        chk("emit_rst_ending", ending, 0);
        chk("emit_rst_rd", dir_rd, 0);
        rst       = 0;
        en_traceB = 0;
        @(negedge clk);
        chk("post_rst_idle", dir_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nw_traceback.md
# nw_traceback

Traceback stage of the Needleman-Wunsch aligner, enabled by the controller's `en_traceB` output and returning its `ending` input. Starts at cell (N,N) of the direction matrix written during fill and walks back to (0,0). Each step reads one direction code and emits one aligned symbol pair on a valid/ready stream. Pairs are emitted in reverse order, from the sequence end back to the start.

## Interface
- N, default 8: sequence length; matrix indices run 0..N.
- IDX_W, default $clog2(N+1): row/column index width.
- LEN_W, default $clog2(2*N+1): alignment length counter width.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en_traceB  in  1  level enable from controller
- dir_rd  out  1  direction/sequence read strobe
- dir_row, dir_col  out  IDX_W  matrix cell address (i, j)
- dir_data  in  2  direction code, valid the cycle after dir_rd
- seq_a_addr, seq_b_addr  out  IDX_W  addresses i-1, j-1 (0 when index is 0)
- seq_a_data, seq_b_data  in  2  symbols, same 1-cycle latency as dir_data
- out_valid  out  1; out_ready  in  1: output handshake
- out_a, out_b  out  2  symbols; out_a_gap, out_b_gap  out  1  gap flags
- out_len  out  LEN_W  pairs accepted so far
- ending  out  1  traceback complete (level)
- dir_err  out  1  sticky illegal-code flag

## Operation
- Direction codes: 00 DIAG (i-1, j-1, emit a/b), 01 UP (i-1, emit a/gap), 10 LEFT (j-1, emit gap/b), 11 illegal.
- Symbol codes: A=00, C=01, G=10, T=11. When a gap flag is set, its symbol output is 00.
- States:
  - IDLE: when en_traceB=1, load i=j=N, clear out_len and dir_err, go to FETCH.
  - FETCH: for one cycle, dir_rd=1 with (i,j) and sequence addresses on the bus; go to EMIT.
  - EMIT: register the pair on entry and assert out_valid. On out_valid&&out_ready, update i/j, increment out_len, and go to DONE if the new (i,j)==(0,0), else to FETCH.
  - DONE: ending=1; stay until en_traceB=0, then go to IDLE.
- Boundaries:
  - i==0 && j>0: LEFT is forced; dir_data is ignored.
  - j==0 && i>0: UP is forced; dir_data is ignored.
  - N==0 is not supported.
- Illegal code 11: treated as DIAG and sets dir_err. dir_err clears only on rst or the next start from IDLE.
- en_traceB=0 in any non-IDLE state: next cycle the block is in IDLE with out_valid=0. A partial alignment is abandoned. Re-enabling restarts from (N,N).
- out_len saturates at 2N (unreachable for legal walks).

## Timing
- Reset values: state IDLE, out_valid=0, dir_rd=0, ending=0, dir_err=0, out_len=0. Address, symbol and gap outputs are 0.
- Start latency: en_traceB rises at cycle 0 → FETCH at cycle 1 → out_valid at cycle 2.
- Throughput: one pair per 2 cycles with out_ready held high.
- Stall: while out_valid=1 && out_ready=0, the outputs, i, j and out_len hold stable.
- ending rises the cycle after the final handshake.
- rst has priority over en_traceB in every state.

## Structure
- Shared package nw_pkg holds:
  - direction localparams DIAG/UP/LEFT/ILLEGAL;
  - symbol encodings;
  - the state enum {IDLE, FETCH, EMIT, DONE}.
- Single module; no sub-module. Index decrement and output mux are inline.

## Test plan
- N=4, all cells DIAG, A=ACGT, B=ACGT, out_ready=1 → pairs (T,T),(G,G),(C,C),(A,A), no gaps. out_len=4. ending high 1 cycle after the 4th handshake; first out_valid 2 cycles after en_traceB.
- N=4, all cells UP → 4 pairs (a,gap) T,G,C,A. Then i==0 forces LEFT: 4 pairs (gap,b) T,G,C,A. out_len=8. dir_data is ignored during the forced steps.
- Backpressure: out_ready low for 5 cycles on the 2nd pair → out_a/out_b/out_valid stable and out_len=1 throughout. Completion is delayed by exactly 5 cycles.
- Illegal code 11 at (4,4) → DIAG pair (T,T) emitted, dir_err=1 and held through DONE. dir_err clears on the next start.
- en_traceB dropped after 2 handshakes → IDLE next cycle, out_valid=0, ending=0. Re-raise → first pair is again from (4,4), and out_len restarts at 0.
- rst asserted during EMIT with out_valid=1 → all outputs at reset values on the next edge.
